// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// State encoding and pointer-width helper used by the top and the round-robin selector.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    function automatic int ptr_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// Round-robin picker: first requester at or after ptr, searching cyclically.
// Purely combinational, zero latency; no backpressure of its own.
module fifo_wr_arbiter_rr_select
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int PTR_W = ptr_w(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PORTS-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic [PTR_W-1:0] j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 0; k < PORTS; k++) begin
            j = PTR_W'((int'(ptr) + k) % PORTS);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among PORTS streams with round-robin, frame- or beat-locked grants.
// First acceptance one cycle after valid, then 1 beat/cycle; fifo_full stalls the granted source only.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int WIDTH      = 512,
    parameter int LOCK_FRAME = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS*WIDTH-1:0] s_data,
    input  logic [PORTS-1:0]       s_valid,
    input  logic [PORTS-1:0]       s_last,
    output logic [PORTS-1:0]       s_ready,
    output logic                   fifo_wr_en,
    output logic [WIDTH-1:0]       fifo_data,
    input  logic                   fifo_full,
    output logic [PORTS-1:0]       grant,
    output logic                   busy
);

    localparam int PTR_W = ptr_w(PORTS);

    state_e           state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] gidx_q, gidx_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             acc_q, acc_d;

    logic [WIDTH-1:0] src_dat [PORTS];
    logic [PTR_W-1:0] g_next;
    logic [PTR_W-1:0] sel_ptr;
    logic [PORTS-1:0] sel_gnt;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_any;
    logic             xfer;
    logic             release_beat;

    for (genvar i = 0; i < PORTS; i++) begin : g_src
        assign src_dat[i] = s_data[i*WIDTH +: WIDTH];
    end

    assign xfer       = (state_q == ST_XFER);
    assign s_ready    = (xfer && !fifo_full) ? grant_q : '0;
    assign fifo_wr_en = xfer && s_valid[gidx_q] && !fifo_full;
    assign fifo_data  = src_dat[gidx_q];
    assign grant      = grant_q;
    assign busy       = xfer;

    assign g_next       = (gidx_q == PTR_W'(PORTS - 1)) ? '0 : gidx_q + 1'b1;
    assign release_beat = fifo_wr_en && ((LOCK_FRAME == 0) || s_last[gidx_q]);
    // On a release beat the current owner drops to lowest priority for the re-pick.
    assign sel_ptr      = release_beat ? g_next : rr_ptr_q;

    fifo_wr_arbiter_rr_select #(
        .PORTS (PORTS),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req (s_valid),
        .ptr (sel_ptr),
        .gnt (sel_gnt),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    state_d = ST_XFER;
                    grant_d = sel_gnt;
                    gidx_d  = sel_idx;
                    acc_d   = 1'b0;
                end
            end
            ST_XFER: begin
                if (release_beat) begin
                    rr_ptr_d = g_next;
                    acc_d    = 1'b0;
                    if (sel_any) begin
                        grant_d = sel_gnt;
                        gidx_d  = sel_idx;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (fifo_wr_en) begin
                    acc_d = 1'b1;
                end else if (!acc_q && !s_valid[gidx_q]) begin
                    // Source withdrew valid before its first beat: give the port back.
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            acc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: frame-locked and beat-locked instances against a queue-based source/arbiter model.
module tb_fifo_wr_arbiter;

    localparam int P = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [P*W-1:0] s_data     [2];
    logic [P-1:0]   s_valid    [2];
    logic [P-1:0]   s_last     [2];
    logic [P-1:0]   s_ready    [2];
    logic [P-1:0]   grant      [2];
    logic           fifo_wr_en [2];
    logic           fifo_full  [2];
    logic           busy       [2];
    logic [W-1:0]   fifo_data  [2];

    fifo_wr_arbiter #(.PORTS(P), .WIDTH(W), .LOCK_FRAME(0)) u_dut0 (
        .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
        .s_ready(s_ready[0]), .fifo_wr_en(fifo_wr_en[0]), .fifo_data(fifo_data[0]),
        .fifo_full(fifo_full[0]), .grant(grant[0]), .busy(busy[0])
    );

    fifo_wr_arbiter #(.PORTS(P), .WIDTH(W), .LOCK_FRAME(1)) u_dut1 (
        .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
        .s_ready(s_ready[1]), .fifo_wr_en(fifo_wr_en[1]), .fifo_data(fifo_data[1]),
        .fifo_full(fifo_full[1]), .grant(grant[1]), .busy(busy[1])
    );

    // Source queues hold {last, data}; index m*P+port, instance m frame-locked when m==1.
    logic [W:0]   srcq  [2*P][$];
    int           gap   [2*P];
    int           seqn  [2*P];
    int           owner [2];
    int           mptr  [2];
    bit           accd  [2];
    logic [W-1:0] wlog  [2][$];
    logic [9:0]   trace [2][$];
    logic [W-1:0] exq   [$];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en, gen_en, rnd_full;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int winner(input logic [P-1:0] v, input int from);
        for (int k = 0; k < P; k++) begin
            if (v[(from + k) % P]) return (from + k) % P;
        end
        return -1;
    endfunction

    task automatic push_frame(input int m, input int port, input int len, input logic [W-1:0] base);
        logic [W-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = base + W'(b);
            srcq[m*P+port].push_back({(b == len - 1), d});
        end
    endtask

    task automatic drive();
        int k;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < P; i++) begin
                k = m*P + i;
                if (srcq[k].size() > 0 && gap[k] == 0) begin
                    s_valid[m][i]        = 1'b1;
                    s_last[m][i]         = srcq[k][0][W];
                    s_data[m][i*W +: W]  = srcq[k][0][W-1:0];
                end else begin
                    s_valid[m][i]        = 1'b0;
                    s_last[m][i]         = 1'b0;
                    s_data[m][i*W +: W]  = '0;
                end
            end
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model past the next edge.
    task automatic check_update(input int m);
        logic [P-1:0] v, eg, er;
        logic         ew;
        logic [W:0]   head;
        int           own, q;
        v    = s_valid[m];
        own  = owner[m];
        eg   = (own >= 0) ? (P'(1) << own) : '0;
        er   = (own >= 0 && !fifo_full[m]) ? eg : '0;
        ew   = (own >= 0) && v[own] && !fifo_full[m];
        head = '0;
        q    = m*P + ((own >= 0) ? own : 0);
        trace[m].push_back({grant[m], s_ready[m], busy[m], fifo_wr_en[m]});
        if (fifo_wr_en[m]) wlog[m].push_back(fifo_data[m]);
        if (chk_en) begin
            chk($sformatf("m%0d grant", m), grant[m], eg);
            chk($sformatf("m%0d s_ready", m), s_ready[m], er);
            chk($sformatf("m%0d wr_en", m), fifo_wr_en[m], ew);
            chk($sformatf("m%0d busy", m), busy[m], own >= 0);
            if (ew) chk($sformatf("m%0d data", m), fifo_data[m], srcq[q][0][W-1:0]);
        end
        for (int k = m*P; k < m*P + P; k++) if (gap[k] > 0) gap[k]--;
        if (ew) head = srcq[q].pop_front();
        if (rst) begin
            owner[m] = -1;
            mptr[m]  = 0;
            accd[m]  = 0;
        end else if (own < 0) begin
            owner[m] = winner(v, mptr[m]);
            accd[m]  = 0;
        end else if (ew && (m == 0 || head[W])) begin
            mptr[m]  = (own + 1) % P;
            owner[m] = winner(v, mptr[m]);
            accd[m]  = 0;
        end else if (ew) begin
            accd[m] = 1;
            if (m == 1 && gen_en && $urandom_range(0, 3) == 0) gap[q] = $urandom_range(1, 2);
        end else if (!accd[m] && !v[own]) begin
            owner[m] = -1;
        end
    endtask

    task automatic step();
        int len;
        if (gen_en) begin
            for (int k = 0; k < 2*P; k++) begin
                if (srcq[k].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 4);
                    push_frame(k / P, k % P, len, W'(((k % P) << 6) | (seqn[k] & 63)));
                    seqn[k] += len;
                end
            end
        end
        if (rnd_full) begin
            fifo_full[0] = ($urandom_range(0, 4) == 0);
            fifo_full[1] = ($urandom_range(0, 4) == 0);
        end
        drive();
        #1;
        check_update(0);
        check_update(1);
        @(negedge clk);
    endtask

    function automatic bit pending();
        for (int k = 0; k < 2*P; k++) if (srcq[k].size() > 0) return 1;
        return (owner[0] >= 0) || (owner[1] >= 0);
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        chk("drain timeout", pending(), 0);
    endtask

    task automatic clr();
        for (int m = 0; m < 2; m++) begin
            wlog[m].delete();
            trace[m].delete();
        end
        exq.delete();
    endtask

    task automatic chk_log(input int m, input string name);
        chk({name, " count"}, wlog[m].size(), exq.size());
        for (int i = 0; i < exq.size() && i < wlog[m].size(); i++)
            chk($sformatf("%s[%0d]", name, i), wlog[m][i], exq[i]);
    endtask

    initial begin
        rst = 1'b1;
        chk_en = 0; gen_en = 0; rnd_full = 0;
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1; mptr[m] = 0; accd[m] = 0; fifo_full[m] = 1'b0;
        end
        for (int k = 0; k < 2*P; k++) begin
            gap[k] = 0; seqn[k] = 0;
        end

        // Reset
        step();
        chk_en = 1;
        clr();
        step();
        chk("reset m0 outputs", trace[0][0], 10'd0);
        chk("reset m1 outputs", trace[1][0], 10'd0);
        rst = 1'b0;

        // All four ports, 2-beat frames, frame-locked
        clr();
        for (int p = 0; p < P; p++) begin
            push_frame(1, p, 2, W'(p*16));
            for (int b = 0; b < 2; b++) exq.push_back(W'(p*16 + b));
        end
        drain(40);
        chk_log(1, "allports");
        for (int k = 0; k < 10 && k < trace[1].size(); k++) begin
            chk($sformatf("allports busy@%0d", k), trace[1][k][1], k >= 1);
            chk($sformatf("allports wr@%0d", k), trace[1][k][0], k >= 1 && k <= 8);
        end

        // Port 1 frame, port 2 requests mid-frame
        clr();
        push_frame(1, 1, 4, 8'h10);
        step();
        step();
        push_frame(1, 2, 2, 8'h20);
        drain(40);
        exq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21};
        chk_log(1, "nointerleave");

        // fifo_full for 5 cycles mid-frame on port 3
        clr();
        push_frame(1, 3, 4, 8'h30);
        step();
        step();
        fifo_full[1] = 1'b1;
        repeat (5) step();
        for (int k = 2; k < 7; k++) begin
            chk($sformatf("full wr@%0d", k), trace[1][k][0], 0);
            chk($sformatf("full ready@%0d", k), trace[1][k][5:2], 0);
        end
        fifo_full[1] = 1'b0;
        drain(40);
        exq = '{8'h30, 8'h31, 8'h32, 8'h33};
        chk_log(1, "fullstall");

        // Beat-locked: ports 0 and 2 continuously valid
        clr();
        push_frame(0, 0, 4, 8'h00);
        push_frame(0, 2, 4, 8'h20);
        drain(40);
        for (int b = 0; b < 4; b++) begin
            exq.push_back(W'(b));
            exq.push_back(W'(8'h20 + b));
        end
        chk_log(0, "alternate");
        for (int k = 1; k <= 8 && k < trace[0].size(); k++)
            chk($sformatf("alternate wr@%0d", k), trace[0][k][0], 1);

        // Reset mid-frame on port 1
        clr();
        push_frame(1, 1, 4, 8'h10);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2*P; k++) begin
            srcq[k].delete();
            gap[k] = 0;
        end
        push_frame(1, 1, 1, 8'h18);
        push_frame(1, 3, 1, 8'h38);
        step();
        chk("post-reset grant", trace[1][4][9:6], 0);
        chk("post-reset s_ready", trace[1][4][5:2], 0);
        chk("post-reset wr_en", trace[1][4][0], 0);
        drain(40);
        exq = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h38};
        chk_log(1, "resetmid");

        // Single requester, three 1-beat frames
        clr();
        push_frame(1, 2, 1, 8'h2a);
        push_frame(1, 2, 1, 8'h2b);
        push_frame(1, 2, 1, 8'h2c);
        drain(40);
        exq = '{8'h2a, 8'h2b, 8'h2c};
        chk_log(1, "single");
        for (int k = 1; k <= 3 && k < trace[1].size(); k++) begin
            chk($sformatf("single grant@%0d", k), trace[1][k][9:6], 4'b0100);
            chk($sformatf("single wr@%0d", k), trace[1][k][0], 1);
        end

        // Randomized traffic, random full, random mid-frame stalls
        clr();
        gen_en = 1;
        rnd_full = 1;
        repeat (3000) step();
        gen_en = 0;
        rnd_full = 0;
        fifo_full[0] = 1'b0;
        fifo_full[1] = 1'b0;
        drain(1000);
        for (int k = 0; k < 2*P; k++)
            chk($sformatf("leftover beats q%0d", k), srcq[k].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
